// File: rtl/spi_write_arbiter.sv
// spi_write_arbiter: two-requester register-write arbiter driving one SPI
// mode-0 frame per accepted write: {1'b1, addr[6:0], data[7:0]}, MSB first.
// Optional feature macro: SPI_ARB_ROUND_ROBIN_EN selects round-robin tie
// breaking. When it is undefined, requester 0 wins ties (fixed priority).
//
// Handshake: a write is accepted on a posedge where reqN_valid && reqN_ready.
// reqN_ready is combinational, high only in IDLE, out of reset, for the
// granted requester whose valid is high. A requester keeps addr/data stable
// while valid is high and ready is low. It may drop valid before acceptance.
module spi_write_arbiter #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // One counter serves the SCLK half-periods, HOLD and GAP.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(16);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(CLK_DIV - 1);
    // GAP lasts GAP_CYCLES-1 cycles. The single IDLE cycle that follows
    // completes the nCS-high gap, so the next accept lands GAP_CYCLES
    // cycles after nCS rose.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(15);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_phase;
    logic [BIT_W-1:0] r_bit;
    logic [15:0]      r_shift;
    logic             r_id;
    logic             r_sclk;
    logic             r_ncs;
    logic             r_copi;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;
    logic             w_grant;
    logic             w_idle_ok;
    logic             w_accept;
    logic             w_phase_end;
    logic [15:0]      w_frame;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic r_ptr;

    // On a tie, grant the requester that was not granted last.
    assign w_grant = (req0_valid && req1_valid) ? ~r_ptr : ~req0_valid;

    // Pointer remembers the last granted requester and moves only on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= w_grant;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    assign w_grant = ~req0_valid;
`endif

    assign w_idle_ok   = (r_state == S_IDLE) && reset;
    assign req0_ready  = w_idle_ok && req0_valid && !w_grant;
    assign req1_ready  = w_idle_ok && req1_valid && w_grant;
    assign w_accept    = req0_ready || req1_ready;
    assign w_phase_end = (r_phase == PH_LAST);
    assign w_frame     = w_grant ? {1'b1, req1_addr, req1_data}
                                 : {1'b1, req0_addr, req0_data};

    assign SCLK      = r_sclk;
    assign nCS       = r_ncs;
    assign COPI      = r_copi;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign dbg_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
            S_SHIFT: if (w_phase_end && r_sclk && (r_bit == BIT_LAST)) w_state_next = S_HOLD;
            S_HOLD:  if (w_phase_end) w_state_next = S_GAP;
            S_GAP:   if (r_phase == GAP_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered serial outputs, counters and frame shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
            r_copi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_id      <= 1'b0;
            r_shift   <= '0;
            r_phase   <= '0;
            r_bit     <= '0;
        end else begin
            r_done  <= 1'b0;
            r_phase <= r_phase + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (w_accept) begin
                        r_shift <= w_frame;
                        r_id    <= w_grant;
                        r_ncs   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_copi  <= w_frame[15];
                        r_busy  <= 1'b1;
                        r_bit   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit unless this was bit 0.
                            r_sclk <= 1'b0;
                            if (r_bit != BIT_LAST) begin
                                r_bit   <= r_bit + BIT_W'(1);
                                r_copi  <= r_shift[14];
                                r_shift <= {r_shift[14:0], 1'b0};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_phase   <= '0;
                        r_ncs     <= 1'b1;
                        r_copi    <= 1'b0;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end
                end
                S_GAP: begin
                    if (r_phase == GAP_LAST) begin
                        r_phase <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_phase <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Self-checking bench for spi_write_arbiter (default parameters).
module tb_spi_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       SCLK, nCS, COPI, busy, done, done_id;
  logic [1:0] dbg_state;

  spi_write_arbiter #(.CLK_DIV(4), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .SCLK(SCLK), .nCS(nCS), .COPI(COPI), .busy(busy), .done(done), .done_id(done_id),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // scoreboard: expected {done_id, frame} in completion order
  logic [16:0] exp_q[$];

  // monitor state
  logic        prev_sclk = 1'b0;
  logic        prev_ncs = 1'b1;
  logic [15:0] rx = '0;
  int          rise_cnt = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  int          last_rise = 0;
  int          last_done_cyc = 0;
  int          acc_cnt = 0;
  int          last_acc = 0;
  int          prev_acc = 0;
  logic        last_acc_id = 1'b0;
  int          ready_viol = 0;

  // monitor: samples between clock edges, after the drivers have settled
  always @(negedge clk) begin
    logic [16:0] e;
    #2;
    if (!nCS && prev_ncs) begin
      last_gap = hi_run;
      rise_cnt = 0;
      rx = '0;
    end
    if (nCS) hi_run++; else hi_run = 0;
    if (SCLK && !prev_sclk) begin
      rx = {rx[14:0], COPI};
      rise_cnt++;
    end
    if (done) begin
      done_cnt++;
      last_rise = rise_cnt;
      last_done_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame: got unexpected id=%0d frame=%h required no frame", done_id, rx);
      end else begin
        e = exp_q.pop_front();
        if ({done_id, rx} !== e) begin
          n_fail++;
          $display("FAIL frame: got id=%0d frame=%h required id=%0d frame=%h", done_id, rx, e[16], e[15:0]);
        end
      end
    end
    if (busy && (req0_ready || req1_ready)) ready_viol++;
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      acc_cnt++;
      prev_acc = last_acc;
      last_acc = cyc + 1;
      last_acc_id = req1_valid && req1_ready;
    end
    prev_sclk = SCLK;
    prev_ncs = nCS;
  end

  // driver helpers
  task automatic wait_acc(input int base, input string name);
    for (int k = 0; k < 300 && acc_cnt <= base; k++) begin
      @(negedge clk); #3;
    end
    chk(name, 32'(acc_cnt > base), 32'd1);
  endtask

  task automatic wait_done(input int base, input string name);
    for (int k = 0; k < 400 && done_cnt <= base; k++) begin
      @(negedge clk); #3;
    end
    chk(name, 32'(done_cnt > base), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) begin
      @(negedge clk); #3;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        v0;
    logic [6:0]  a0;
    logic [7:0]  d0;
    logic        v1;
    logic [6:0]  a1;
    logic [7:0]  d1;
    logic        exp_id;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs[7];
  logic tie_order[4];

  initial begin : stim
    int a, dc, first;
    int rem0, rem1;

    vecs[0] = '{1'b1, 7'h04, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b0, 16'h84A5};
    vecs[1] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h02, 8'hFF, 1'b1, 16'h82FF};
    vecs[2] = '{1'b1, 7'h00, 8'h11, 1'b1, 7'h01, 8'h22, 1'b0, 16'h8011};
    vecs[3] = '{1'b1, 7'h7F, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 16'hFF00};
    vecs[4] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h55, 8'h3C, 1'b1, 16'hD53C};
    vecs[5] = '{1'b1, 7'h10, 8'h01, 1'b1, 7'h20, 8'h02, 1'b0, 16'h9001};
    vecs[6] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h7A, 8'hC3, 1'b1, 16'hFAC3};
`ifdef SPI_ARB_ROUND_ROBIN_EN
    tie_order[0] = 1'b0; tie_order[1] = 1'b1; tie_order[2] = 1'b0; tie_order[3] = 1'b1;
`else
    tie_order[0] = 1'b0; tie_order[1] = 1'b0; tie_order[2] = 1'b1; tie_order[3] = 1'b1;
`endif

    // reset values, with a pending valid that must not see ready
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h09; req0_data = 8'h99;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_ncs", 32'(nCS), 32'd1);
    chk("rst_copi", 32'(COPI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single writes and simple ties
    for (int i = 0; i < 7; i++) begin
      a = acc_cnt; dc = done_cnt;
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
      exp_q.push_back({vecs[i].exp_id, vecs[i].exp_frame});
      wait_acc(a, $sformatf("vec%0d_accept", i));
      chk($sformatf("vec%0d_grant", i), 32'(last_acc_id), 32'(vecs[i].exp_id));
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_addr = 7'h6B; req0_data = 8'h5A; req1_addr = 7'h2C; req1_data = 8'hC3;
      wait_done(dc, $sformatf("vec%0d_done", i));
      chk($sformatf("vec%0d_rises", i), 32'(last_rise), 32'd16);
      chk($sformatf("vec%0d_latency", i), 32'(last_done_cyc - last_acc), 32'd132);
      wait_idle();
    end

    // ties with both requesters held valid for two writes each
    for (int k = 0; k < 4; k++)
      exp_q.push_back({tie_order[k], tie_order[k] ? 16'h8122 : 16'h8011});
    rem0 = 2; rem1 = 2;
    @(negedge clk);
    req0_addr = 7'h00; req0_data = 8'h11; req1_addr = 7'h01; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = acc_cnt; dc = done_cnt;
      wait_acc(a, $sformatf("tie%0d_accept", k));
      chk($sformatf("tie%0d_grant", k), 32'(last_acc_id), 32'(tie_order[k]));
      if (k > 0) chk($sformatf("tie%0d_period", k), 32'(last_acc - prev_acc), 32'd136);
      if (last_acc_id) rem1--; else rem0--;
      @(negedge clk);
      req0_valid = (rem0 > 0); req1_valid = (rem1 > 0);
      wait_done(dc, $sformatf("tie%0d_done", k));
      if (k > 0) chk($sformatf("tie%0d_gap", k), 32'(last_gap), 32'd4);
    end
    wait_idle();

    // back-to-back from requester 1
    a = acc_cnt; dc = done_cnt;
    exp_q.push_back({1'b1, 16'h82FF});
    exp_q.push_back({1'b1, 16'h830F});
    @(negedge clk);
    req1_addr = 7'h02; req1_data = 8'hFF; req1_valid = 1'b1;
    wait_acc(a, "b2b_accept0");
    first = last_acc;
    @(negedge clk);
    req1_addr = 7'h03; req1_data = 8'h0F;
    wait_acc(a + 1, "b2b_accept1");
    chk("b2b_period", 32'(last_acc - first), 32'd136);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_done(dc + 1, "b2b_done");
    chk("b2b_gap", 32'(last_gap), 32'd4);
    wait_idle();

    // reset mid-frame after the 7th rising SCLK
    a = acc_cnt;
    @(negedge clk);
    req0_addr = 7'h12; req0_data = 8'h34; req0_valid = 1'b1;
    wait_acc(a, "rst_accept");
    for (int k = 0; k < 200 && rise_cnt < 7; k++) begin
      @(negedge clk); #3;
    end
    chk("rst_seventh_rise", 32'(rise_cnt), 32'd7);
    reset = 1'b0;
    #1;
    chk("abort_ncs", 32'(nCS), 32'd1);
    chk("abort_sclk", 32'(SCLK), 32'd0);
    chk("abort_copi", 32'(COPI), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready0", 32'(req0_ready), 32'd0);
    dc = done_cnt;
    repeat (4) @(negedge clk);
    #3;
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    exp_q.push_back({1'b0, 16'h9234});
    @(negedge clk) reset = 1'b1;
    wait_acc(a + 1, "rst_reaccept");
    chk("rst_reaccept_id", 32'(last_acc_id), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_done(dc, "rst_done");
    chk("rst_rises", 32'(last_rise), 32'd16);
    wait_idle();

    // handshake: dropped request and busy-time valids
    a = acc_cnt; dc = done_cnt;
    exp_q.push_back({1'b1, 16'hC455});
    @(negedge clk);
    req1_addr = 7'h44; req1_data = 8'h55; req1_valid = 1'b1;
    wait_acc(a, "hs_accept0");
    @(negedge clk);
    req1_valid = 1'b0;
    req0_addr = 7'h66; req0_data = 8'h77; req0_valid = 1'b1;
    repeat (20) @(negedge clk);
    req0_valid = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back({1'b0, 16'hB546});
    req0_addr = 7'h35; req0_data = 8'h46; req0_valid = 1'b1;
    wait_done(dc, "hs_done0");
    wait_acc(a + 1, "hs_accept1");
    chk("hs_accept1_id", 32'(last_acc_id), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req0_addr = 7'h7F; req0_data = 8'hFF;
    wait_done(dc + 1, "hs_done1");
    wait_idle();
    repeat (20) @(negedge clk);
    #3;
    chk("hs_accept_count", 32'(acc_cnt), 32'(a + 2));
    chk("hs_done_count", 32'(done_cnt), 32'(dc + 2));
    chk("ready_while_busy", 32'(ready_viol), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got still running required finished");
    $fatal(1, "simulation time limit");
  end

endmodule
